// File: rtl/multicycle_control_if.sv
// Bundle between the multicycle sequencer and the LEGv8 datapath/memory port.
// master = sequencer (drives control), slave = datapath side.
interface multicycle_control_if;
    logic [31:0] instruction;
    logic        zeroFlag;
    logic        negFlag;
    logic        overflowFlag;
    logic        memReady;
    logic        pcWrite;
    logic        irWrite;
    logic        memRead;
    logic        memWrite;
    logic        regWrite;
    logic        reg2Loc;
    logic [1:0]  aluSrc;
    logic [2:0]  aluOp;
    logic [1:0]  memToReg;
    logic [1:0]  brTaken;
    logic        flagEn;
    logic        illegal;
    logic [31:0] instrCount;

    modport master (
        input  instruction, zeroFlag, negFlag, overflowFlag, memReady,
        output pcWrite, irWrite, memRead, memWrite, regWrite, reg2Loc,
               aluSrc, aluOp, memToReg, brTaken, flagEn, illegal, instrCount
    );

    modport slave (
        output instruction, zeroFlag, negFlag, overflowFlag, memReady,
        input  pcWrite, irWrite, memRead, memWrite, regWrite, reg2Loc,
               aluSrc, aluOp, memToReg, brTaken, flagEn, illegal, instrCount
    );
endinterface

// File: rtl/multicycle_control.sv
// LEGv8 multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared ALU and
// a single ready-handshaked memory port; HALT on an unknown opcode.
module multicycle_control (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_if.master        bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]  r_state, w_next;
    logic [10:0] r_opcode;
    logic        r_illegal;
    logic [31:0] r_count;

    logic w_addi, w_adds, w_subs, w_b, w_bl, w_blt, w_br, w_cbz, w_ldur, w_stur, w_known;

    always_comb begin
        {w_addi, w_adds, w_subs, w_b, w_bl, w_blt, w_br, w_cbz, w_ldur, w_stur} = '0;
        casez (r_opcode)
            11'b1001000100?: w_addi = 1'b1;
            11'b10101011000: w_adds = 1'b1;
            11'b11101011000: w_subs = 1'b1;
            11'b000101?????: w_b    = 1'b1;
            11'b100101?????: w_bl   = 1'b1;
            11'b01010100???: w_blt  = 1'b1;
            11'b11010110000: w_br   = 1'b1;
            11'b10110100???: w_cbz  = 1'b1;
            11'b11111000010: w_ldur = 1'b1;
            11'b11111000000: w_stur = 1'b1;
            default: ;
        endcase
    end

    assign w_known = |{w_addi, w_adds, w_subs, w_b, w_bl, w_blt, w_br, w_cbz, w_ldur, w_stur};

    logic       w_pc, w_ir, w_mrd, w_mwr, w_rw, w_r2l, w_fe;
    logic [1:0] w_asrc, w_m2r, w_brsel;
    logic [2:0] w_aop;

    // Every retiring path asserts pcWrite exactly once, so w_pc doubles as the retire strobe.
    always_comb begin
        w_next  = r_state;
        w_pc    = 1'b0;
        w_ir    = 1'b0;
        w_mrd   = 1'b0;
        w_mwr   = 1'b0;
        w_rw    = 1'b0;
        w_r2l   = 1'b0;
        w_fe    = 1'b0;
        w_asrc  = 2'b00;
        w_m2r   = 2'b00;
        w_brsel = 2'b00;
        w_aop   = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_mrd = 1'b1;
                if (bus.memReady) begin
                    w_ir   = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_r2l  = w_adds | w_subs;
                w_next = w_known ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                if (w_addi) begin
                    w_asrc = 2'b10;
                    w_aop  = 3'b010;
                    w_next = S_WB;
                end
                if (w_adds | w_subs) begin
                    w_aop  = w_subs ? 3'b011 : 3'b010;
                    w_fe   = 1'b1;
                    w_next = S_WB;
                end
                if (w_ldur | w_stur) begin
                    w_asrc = 2'b01;
                    w_aop  = 3'b010;
                    w_next = S_MEM;
                end
                if (w_b | w_bl) begin
                    w_brsel = 2'b01;
                    w_pc    = 1'b1;
                end
                if (w_bl) begin
                    w_m2r = 2'b10;
                    w_rw  = 1'b1;
                end
                if (w_br) begin
                    w_brsel = 2'b10;
                    w_pc    = 1'b1;
                end
                if (w_blt) begin
                    w_brsel = {1'b0, bus.negFlag ^ bus.overflowFlag};
                    w_pc    = 1'b1;
                end
                if (w_cbz) begin
                    w_brsel = {1'b0, bus.zeroFlag};
                    w_pc    = 1'b1;
                end
            end
            S_MEM: begin
                w_asrc = 2'b01;
                w_aop  = 3'b010;
                w_mrd  = w_ldur;
                w_mwr  = w_stur;
                if (bus.memReady) begin
                    if (w_ldur) w_next = S_WB;
                    else begin
                        w_pc   = 1'b1;
                        w_next = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_rw   = 1'b1;
                w_pc   = 1'b1;
                w_m2r  = w_ldur ? 2'b01 : 2'b00;
                w_next = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_opcode  <= '0;
            r_illegal <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if (w_ir) r_opcode <= bus.instruction[31:21];
            if (r_state == S_DECODE && !w_known) r_illegal <= 1'b1;
            if (w_pc) r_count <= r_count + 32'd1;
        end
    end

    // Control outputs are held low for as long as reset is asserted.
    assign bus.pcWrite    = w_pc  & ~reset;
    assign bus.irWrite    = w_ir  & ~reset;
    assign bus.memRead    = w_mrd & ~reset;
    assign bus.memWrite   = w_mwr & ~reset;
    assign bus.regWrite   = w_rw  & ~reset;
    assign bus.reg2Loc    = w_r2l & ~reset;
    assign bus.flagEn     = w_fe  & ~reset;
    assign bus.aluSrc     = reset ? 2'b00  : w_asrc;
    assign bus.aluOp      = reset ? 3'b000 : w_aop;
    assign bus.memToReg   = reset ? 2'b00  : w_m2r;
    assign bus.brTaken    = reset ? 2'b00  : w_brsel;
    assign bus.illegal    = r_illegal & ~reset;
    assign bus.instrCount = r_count;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is checked against a
// per-instruction summary (latency, strobe counts, selects) derived from the ISA rules.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    multicycle_control_if bus();

    multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    localparam int C_ADDI = 0, C_ADDS = 1, C_SUBS = 2, C_B = 3, C_BL = 4,
                   C_BLT = 5, C_BR = 6, C_CBZ = 7, C_LDUR = 8, C_STUR = 9;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk_op(input int cls);
        logic [10:0] r;
        r = 11'($urandom);
        case (cls)
            C_ADDI:  return {10'b1001000100, r[0]};
            C_ADDS:  return 11'b10101011000;
            C_SUBS:  return 11'b11101011000;
            C_B:     return {6'b000101, r[4:0]};
            C_BL:    return {6'b100101, r[4:0]};
            C_BLT:   return {8'b01010100, r[2:0]};
            C_BR:    return 11'b11010110000;
            C_CBZ:   return {8'b10110100, r[2:0]};
            C_LDUR:  return 11'b11111000010;
            default: return 11'b11111000000;
        endcase
    endfunction

    function automatic logic [15:0] ctl_vec();
        return {bus.pcWrite, bus.irWrite, bus.memRead, bus.memWrite, bus.regWrite,
                bus.reg2Loc, bus.aluSrc, bus.aluOp, bus.memToReg, bus.brTaken,
                bus.flagEn, bus.illegal};
    endfunction

    // One instruction: F fetch stall cycles, M memory stall cycles, flags held constant.
    task automatic run_instr(input int cls, input int F, input int M,
                             input logic z, input logic n, input logic v);
        logic [31:0] cnt0;
        int  wt, lat, nrd, nwr, nrw, nfe, nir, cyc;
        bit  done, ovl, alu, mem;
        logic [1:0] brv, m2rv, asrc_ex, ebr, em2r, easrc;
        logic [2:0] aop_ex, eaop;
        logic r2l_dec;
        string nm;
        nm = $sformatf("c%0d", cls);
        cnt0 = bus.instrCount;
        bus.instruction  = {mk_op(cls), 21'($urandom)};
        bus.zeroFlag     = z;
        bus.negFlag      = n;
        bus.overflowFlag = v;
        wt = F; lat = 0; nrd = 0; nwr = 0; nrw = 0; nfe = 0; nir = 0;
        done = 0; ovl = 0; brv = 0; m2rv = 0; asrc_ex = 0; aop_ex = 0; r2l_dec = 0;
        cyc = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            if (bus.memRead || bus.memWrite) begin
                bus.memReady = (wt == 0);
                if (wt > 0) wt--;
            end else bus.memReady = 1'($urandom);
            #1;
            if (cyc == F + 1) r2l_dec = bus.reg2Loc;
            if (cyc == F + 2) begin asrc_ex = bus.aluSrc; aop_ex = bus.aluOp; end
            nrd += int'(bus.memRead);
            nwr += int'(bus.memWrite);
            nfe += int'(bus.flagEn);
            nir += int'(bus.irWrite);
            if (bus.regWrite) begin nrw++; m2rv = bus.memToReg; end
            if (bus.memRead && bus.memWrite) ovl = 1;
            if ((bus.memRead || bus.memWrite) && bus.memReady) wt = M;
            if (bus.pcWrite) begin brv = bus.brTaken; done = 1; lat = cyc + 1; end
            cyc++;
        end
        chk({nm, " retire"}, 32'(done), 32'd1);
        alu = (cls == C_ADDI || cls == C_ADDS || cls == C_SUBS);
        mem = (cls == C_LDUR || cls == C_STUR);
        chk({nm, " latency"}, lat,
            (alu ? 4 : cls == C_LDUR ? 5 : cls == C_STUR ? 4 : 3) + F + (mem ? M : 0));
        chk({nm, " irWrite"}, nir, 1);
        chk({nm, " memRead"}, nrd, F + 1 + (cls == C_LDUR ? M + 1 : 0));
        chk({nm, " memWrite"}, nwr, cls == C_STUR ? M + 1 : 0);
        chk({nm, " regWrite"}, nrw, (alu || cls == C_LDUR || cls == C_BL) ? 1 : 0);
        chk({nm, " flagEn"}, nfe, (cls == C_ADDS || cls == C_SUBS) ? 1 : 0);
        chk({nm, " rw_mem"}, 32'(ovl), 0);
        chk({nm, " reg2Loc"}, 32'(r2l_dec), (cls == C_ADDS || cls == C_SUBS) ? 1 : 0);
        case (cls)
            C_B, C_BL: ebr = 2'b01;
            C_BR:      ebr = 2'b10;
            C_BLT:     ebr = {1'b0, n ^ v};
            C_CBZ:     ebr = {1'b0, z};
            default:   ebr = 2'b00;
        endcase
        chk({nm, " brTaken"}, 32'(brv), 32'(ebr));
        em2r = (cls == C_LDUR) ? 2'b01 : (cls == C_BL) ? 2'b10 : 2'b00;
        chk({nm, " memToReg"}, 32'(m2rv), 32'(em2r));
        case (cls)
            C_ADDI:         begin easrc = 2'b10; eaop = 3'b010; end
            C_ADDS:         begin easrc = 2'b00; eaop = 3'b010; end
            C_SUBS:         begin easrc = 2'b00; eaop = 3'b011; end
            C_LDUR, C_STUR: begin easrc = 2'b01; eaop = 3'b010; end
            default:        begin easrc = 2'b00; eaop = 3'b000; end
        endcase
        chk({nm, " aluSrc"}, 32'(asrc_ex), 32'(easrc));
        chk({nm, " aluOp"}, 32'(aop_ex), 32'(eaop));
        @(posedge clk); #1;
        chk({nm, " instrCount"}, bus.instrCount, cnt0 + 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        bus.instruction = '0;
        bus.zeroFlag = 0; bus.negFlag = 0; bus.overflowFlag = 0;
        bus.memReady = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("reset outputs", 32'(ctl_vec()), 32'd0);
        chk("reset count", bus.instrCount, 32'd0);
        bus.memReady = 1'b0;
        reset = 1'b0;
        #1;
        chk("first memRead", 32'(bus.memRead), 32'd1);

        run_instr(C_ADDI, 0, 0, 0, 0, 0);
        run_instr(C_LDUR, 0, 2, 0, 0, 0);
        run_instr(C_STUR, 0, 0, 0, 0, 0);
        run_instr(C_SUBS, 1, 0, 0, 0, 0);
        run_instr(C_BLT,  0, 0, 0, 1, 0);
        run_instr(C_BLT,  0, 0, 0, 1, 1);
        run_instr(C_CBZ,  0, 0, 0, 0, 0);
        run_instr(C_CBZ,  0, 0, 1, 0, 0);
        run_instr(C_BL,   0, 0, 0, 0, 0);
        run_instr(C_BR,   2, 0, 1, 1, 0);
        run_instr(C_B,    0, 0, 0, 0, 1);
        run_instr(C_ADDS, 0, 0, 1, 0, 1);

        for (int k = 0; k < 60; k++)
            run_instr($urandom_range(9), $urandom_range(2), $urandom_range(3),
                      1'($urandom), 1'($urandom), 1'($urandom));

        // Reset while an LDUR is stalled in MEM.
        @(negedge clk);
        bus.instruction = {11'b11111000010, 21'($urandom)};
        bus.memReady = 1'b1;
        @(negedge clk); bus.memReady = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("midmem memRead", 32'(bus.memRead), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midmem count", bus.instrCount, 32'd0);
        chk("midmem outputs", 32'(ctl_vec()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midmem refetch", 32'(bus.memRead), 32'd1);

        run_instr(C_ADDI, 0, 0, 0, 0, 0);

        // Unknown opcode halts; reset from HALT recovers.
        @(negedge clk);
        bus.instruction = {11'h000, 21'($urandom)};
        bus.memReady = 1'b1;
        @(negedge clk); #1;
        chk("decode illegal", 32'(bus.illegal), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.memReady = 1'($urandom);
            #1;
            chk("halt illegal", 32'(bus.illegal), 32'd1);
            chk("halt memRead", 32'(bus.memRead), 32'd0);
            chk("halt pcWrite", 32'(bus.pcWrite), 32'd0);
            chk("halt count", bus.instrCount, 32'd1);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.memReady = 1'b0;
        #1;
        chk("halt reset memRead", 32'(bus.memRead), 32'd1);
        chk("halt reset illegal", 32'(bus.illegal), 32'd0);
        chk("halt reset count", bus.instrCount, 32'd0);

        run_instr(C_LDUR, 1, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the LEGv8 core. It replaces the one-shot combinational decode with a state machine that spreads each instruction over FETCH/DECODE/EXEC/MEM/WB. This lets the datapath share a single ALU and a single memory port, with a ready handshake on that port. It drives the existing datapath control signals (reg2Loc, aluSrc, aluOp, memToReg, brTaken, flagEn, regWrite, memWrite) and adds pcWrite, irWrite and memRead.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- instruction  in  32  memory read-data bus. Bits [31:21] are captured into the internal opcode register on the FETCH accept cycle.
- zeroFlag  in  1  live ALU zero output, used by CBZ.
- negFlag, overflowFlag  in  1 each  stored flag-register outputs, used by BLT.
- memReady  in  1  memory port completes the current read or write this cycle.
- pcWrite  out  1  PC register load enable.
- irWrite  out  1  instruction register load enable.
- memRead  out  1  memory read request.
- memWrite  out  1  memory write request.
- regWrite  out  1  register file write enable.
- reg2Loc  out  1  selects register read port 2 (1 = Rm, 0 = Rt).
- aluSrc  out  2  ALU B-operand select (00 = reg, 01 = DAddr9, 10 = Imm12).
- aluOp  out  3  ALU operation (000 = pass B, 010 = add, 011 = sub).
- memToReg  out  2  writeback select (00 = ALU, 01 = memory, 10 = PC+4).
- brTaken  out  2  next-PC select (00 = PC+4, 01 = PC+offset, 10 = Rd register).
- flagEn  out  1  flag register load enable.
- illegal  out  1  sticky flag: an unknown opcode was decoded.
- instrCount  out  32  count of retired instructions.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. The state register is internal.
- Opcode decode uses instruction[31:21]:
  - ADDI 1001000100x
  - ADDS 10101011000
  - SUBS 11101011000
  - B 000101xxxxx
  - BL 100101xxxxx
  - BLT 01010100xxx
  - BR 11010110000
  - CBZ 10110100xxx
  - LDUR 11111000010
  - STUR 11111000000
- Outputs are decoded from the state and the latched opcode. Any output not listed for a state is 0.
- FETCH:
  - memRead=1 each cycle until memReady.
  - On memReady: irWrite=1, latch opcode, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Drive reg2Loc: 1 for ADDS/SUBS, 0 otherwise.
  - Unknown opcode: go to HALT and set illegal.
  - All known opcodes: go to EXEC.
- EXEC:
  - ADDI: aluSrc=10, aluOp=010. Go to WB.
  - ADDS: aluSrc=00, aluOp=010, flagEn=1. Go to WB.
  - SUBS: aluSrc=00, aluOp=011, flagEn=1. Go to WB.
  - LDUR/STUR: aluSrc=01, aluOp=010. Go to MEM.
  - B: brTaken=01, pcWrite=1. Retire, go to FETCH.
  - BL: brTaken=01, memToReg=10, regWrite=1 (writes X30), pcWrite=1. Retire, go to FETCH.
  - BR: brTaken=10, pcWrite=1. Retire, go to FETCH.
  - BLT: brTaken={0, negFlag^overflowFlag}, pcWrite=1. Retire, go to FETCH.
  - CBZ: aluSrc=00, aluOp=000, brTaken={0, zeroFlag}, pcWrite=1, flagEn=0. Retire, go to FETCH.
- MEM:
  - Hold aluSrc=01 and aluOp=010.
  - LDUR: memRead=1. On memReady go to WB.
  - STUR: memWrite=1. On memReady: pcWrite=1, brTaken=00, retire, go to FETCH.
  - Without memReady, stay in MEM with the same outputs.
- WB:
  - regWrite=1, pcWrite=1, brTaken=00.
  - memToReg=01 for LDUR, 00 otherwise.
  - Retire, go to FETCH.
- HALT: all outputs 0 and illegal=1. Stay in HALT until reset.
- Retire: instrCount increments by 1 at the end of a retiring cycle. It wraps from 0xFFFFFFFF to 0.

## Timing
- On reset:
  - state=FETCH, opcode register=0, illegal=0, instrCount=0.
  - While reset is high, all control outputs are forced to 0.
  - Reset asserted in any state, including mid-MEM or HALT, takes effect at the next edge.
  - The first memRead is asserted in the cycle after reset deasserts.
- Latency with memReady tied high:
  - ALU ops: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - Branches: 3 cycles.
- Each cycle memReady is low in FETCH or MEM adds one cycle.
- memReady is ignored in DECODE, EXEC, WB and HALT.
- Branch decisions use flag values sampled in the EXEC cycle.
- ADDS/SUBS update the flags at the end of EXEC. A BLT that directly follows therefore sees the new flags.
- Exactly one pcWrite pulse occurs per retired instruction.
- irWrite pulses only on a FETCH cycle with memReady high.
- memRead and memWrite are never asserted together.

## Test plan
- Reset, then ADDI with memReady=1. Required sequence: memRead+irWrite, DECODE, EXEC with aluSrc=10/aluOp=010, WB with regWrite=1/pcWrite=1. instrCount goes 0 to 1 after 4 cycles.
- LDUR with memReady low for 2 MEM cycles. memRead is held for 3 MEM cycles, then WB with memToReg=01. Total 7 cycles.
- STUR with memReady=1. memWrite=1 in MEM together with pcWrite=1. regWrite stays 0 throughout.
- SUBS producing negative with no overflow, then BLT. SUBS pulses flagEn. BLT drives brTaken=01 with negFlag=1/overflowFlag=0, and brTaken=00 when both flags are 1.
- CBZ with zeroFlag=0, then with zeroFlag=1. brTaken=00, then 01. pcWrite=1 in EXEC both times. Also BL: regWrite=1, memToReg=10.
- Opcode 0x000. DECODE goes to HALT, illegal=1, no further memRead. Reset asserted in HALT and also mid-MEM returns to FETCH with instrCount=0.
